mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Parametrised successor to the pass-through MEM stage of the RISC-V pipeline.
- Executes loads and stores against a data-memory port with a request/grant/response handshake, using LB/LH/LW/LBU/LHU/SB/SH/SW lane steering and sign/zero extension.
- Sits between EX and WB. Integrates the MEM/WB register, raises a pipeline stall while an access is outstanding, and drives forwarding back to ID.

Parameters:
- XLEN, 32, data/register width; multiple of 8, at least 32.
- ADDR_W, 32, data-memory byte-address width.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  in  1  stage clock, rising edge.
- rst  in  1  reset; one clock, asynchronous assert, active-low.
- valid_i  in  1  EX presents an instruction this cycle.
- wd_i  in  REG_ADDR_W  destination register.
- wreg_i  in  1  instruction writes rd.
- wdata_i  in  XLEN  ALU result, used for non-memory ops.
- mem_op_i  in  4  memory op code (MEM_NONE, LB, LH, LW, LBU, LHU, SB, SH, SW).
- mem_addr_i  in  ADDR_W  effective byte address.
- store_data_i  in  XLEN  rs2 value for stores.
- dm_req_o  out  1  data-memory request.
- dm_we_o  out  1  request is a write.
- dm_addr_o  out  ADDR_W  word-aligned address, low 2 bits zero.
- dm_wdata_o  out  XLEN  lane-replicated store data.
- dm_wstrb_o  out  XLEN/8  byte strobes.
- dm_gnt_i  in  1  request accepted this cycle.
- dm_rvalid_i  in  1  read data valid.
- dm_rdata_i  in  XLEN  read data.
- stall_o  out  1  hold EX and earlier stages.
- misalign_o  out  1  one-cycle misaligned-access flag.
- wd_o  out  REG_ADDR_W  to WB, registered.
- wreg_o  out  1  to WB, registered.
- wdata_o  out  XLEN  to WB, registered.
- mem_wd_o  out  REG_ADDR_W  forwarding to ID.
- mem_wreg_o  out  1  forwarding to ID.
- mem_wdata_o  out  XLEN  forwarding to ID.

Behaviour:
- Reset: state IDLE; all registered outputs zero; dm_req_o=0; stall_o=0; misalign_o=0.
- FSM states:
  - IDLE: capture the op.
  - REQ: request held, awaiting dm_gnt_i.
  - WAIT: load granted, awaiting dm_rvalid_i.
- Non-memory op (valid_i, MEM_NONE): wd/wreg/wdata registered to WB next edge; latency 1; no stall.
- Alignment rule:
  - Halfword ops require addr[0]=0.
  - Word ops require addr[1:0]=0.
  - On violation: no dm request; misalign_o=1 for that cycle; wreg_o=0 next edge; no stall.
- Memory op in IDLE:
  - dm_req_o asserted combinationally the same cycle.
  - Op fields latched at the edge.
  - stall_o asserted unless the op completes this cycle.
- Request hold: dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o and dm_wstrb_o stay stable from the first assertion until the cycle of dm_gnt_i.
- Stores:
  - Complete on dm_gnt_i; return to IDLE; wreg_o=0.
  - Strobe patterns: SB = 4'b0001 << addr[1:0]; SH = 4'b0011 << addr[1:0]; SW = 4'b1111.
  - Data replicated across lanes.
- Loads: after grant go to WAIT (grant may coincide with the request cycle). On dm_rvalid_i:
  - Lane is selected by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Result registered to wdata_o; return to IDLE.
- Stall timing: stall_o is 1 in every cycle an access is outstanding, except the completing cycle (store gnt or load rvalid). EX advances on that edge.
- Back-to-back: a new op may be accepted in the cycle after completion.
- dm_rvalid_i: ignored outside WAIT; dm_rvalid_i in the grant cycle is not permitted.
- Forwarding:
  - Non-load: mem_* mirrors the current-cycle inputs (as prior generation).
  - Load: mem_wreg_o=0 until the completing cycle, then carries the extended load data combinationally.
- valid_i=0 in IDLE: wreg_o=0 next edge (bubble).
- Reset mid-access: immediate return to IDLE and dm_req_o drops. A late dm_rvalid_i after reset is ignored.

Decomposition:
- Shared definitions in define.v:
  - memory op encodings (MEM_NONE, MEM_LB, …);
  - FSM state encoding;
  - ZeroWord, NOPRegAddr, WriteEnable/Disable.
- One combinational sub-module, mem_load_align: (rdata, addr[1:0], op) -> extended XLEN result. Reused by any future cache bypass path.

Test Plan:
- ADD result: valid, MEM_NONE, wd=5, wdata=0x1234 -> next edge wd_o=5, wreg_o=1, wdata_o=0x1234; stall_o never high.
- LB at 0x1003, rdata=0x80FFFFFF:
  - gnt same cycle, rvalid 2 cycles later;
  - wdata_o=0xFFFFFF80;
  - stall_o high exactly 2 cycles.
- LHU at 0x1002, rdata=0xBEEF0000, gnt delayed 3 cycles:
  - req/addr held stable;
  - wdata_o=0x0000BEEF.
- SB at 0x2001, data 0xAB -> dm_wstrb_o=0010, dm_wdata_o=0xABABABAB, dm_addr_o=0x2000, wreg_o=0.
- LW at 0x3002 -> misalign_o=1 one cycle, dm_req_o stays 0, wreg_o=0.
- Reset mid-access: rst low during WAIT -> outputs zero, IDLE. rvalid pulse after release -> no WB write.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: memory op encodings, FSM state
// encoding, write-enable constants and op classification helpers.
package mem_access_stage_pkg;

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LH   = 4'd2;
  localparam logic [3:0] MEM_LW   = 4'd3;
  localparam logic [3:0] MEM_LBU  = 4'd4;
  localparam logic [3:0] MEM_LHU  = 4'd5;
  localparam logic [3:0] MEM_SB   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SW   = 4'd8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic [4:0] NOP_REG_ADDR = 5'd0;

  function automatic logic is_load(input logic [3:0] op);
    return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  // Halfword accesses need an even address, word accesses a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lane);
    if (op inside {MEM_LH, MEM_LHU, MEM_SH}) return lane[0];
    if (op inside {MEM_LW, MEM_SW})          return lane != 2'b00;
    return 1'b0;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword/word of a read beat and sign- or
// zero-extends it to XLEN; shared with any future cache bypass path.
module mem_load_align
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      addr_i,
  input  logic [3:0]      op_i,
  output logic [XLEN-1:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  always_comb begin
    byte_v = rdata_i[{addr_i, 3'b000} +: 8];
    half_v = rdata_i[{addr_i[1], 4'b0000} +: 16];
    word_v = rdata_i[31:0];
    case (op_i)
      MEM_LB:  result_o = XLEN'($signed(byte_v));
      MEM_LBU: result_o = XLEN'(byte_v);
      MEM_LH:  result_o = XLEN'($signed(half_v));
      MEM_LHU: result_o = XLEN'(half_v);
      MEM_LW:  result_o = XLEN'($signed(word_v));
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads/stores over a req/gnt/rvalid data-memory
// port, stalls EX while an access is outstanding and owns the MEM/WB register.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [XLEN-1:0]       wdata_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [XLEN-1:0]       store_data_i,
  output logic                  dm_req_o,
  output logic                  dm_we_o,
  output logic [ADDR_W-1:0]     dm_addr_o,
  output logic [XLEN-1:0]       dm_wdata_o,
  output logic [XLEN/8-1:0]     dm_wstrb_o,
  input  logic                  dm_gnt_i,
  input  logic                  dm_rvalid_i,
  input  logic [XLEN-1:0]       dm_rdata_i,
  output logic                  stall_o,
  output logic                  misalign_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [XLEN-1:0]       wdata_o,
  output logic [REG_ADDR_W-1:0] mem_wd_o,
  output logic                  mem_wreg_o,
  output logic [XLEN-1:0]       mem_wdata_o
);

  localparam int NB = XLEN / 8;

  logic [1:0]            state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [1:0]            lane_q, lane_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  rd_we_q, rd_we_d;
  logic [XLEN-1:0]       st_data_q, st_data_d;
  logic [NB-1:0]         st_strb_q, st_strb_d;
  logic [REG_ADDR_W-1:0] wd_q, wd_d;
  logic                  wreg_q, wreg_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;

  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_data;
  logic [NB-1:0]     req_strb;
  logic [XLEN-1:0]   load_result;
  logic              req, we, stall, misalign, load_done, load_pending;

  mem_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata_i  (dm_rdata_i),
    .addr_i   (lane_q),
    .op_i     (op_q),
    .result_o (load_result)
  );

  // Store data is replicated so every enabled lane already sees its bytes.
  always_comb begin
    req_addr = {mem_addr_i[ADDR_W-1:2], 2'b00};
    req_data = '0;
    req_strb = '0;
    for (int i = 0; i < NB; i++) begin
      case (mem_op_i)
        MEM_SB:  req_data[8*i +: 8] = store_data_i[7:0];
        MEM_SH:  req_data[8*i +: 8] = store_data_i[8*(i%2) +: 8];
        default: req_data[8*i +: 8] = store_data_i[8*(i%4) +: 8];
      endcase
    end
    case (mem_op_i)
      MEM_SB:  req_strb = NB'(1) << mem_addr_i[1:0];
      MEM_SH:  req_strb = NB'(3) << mem_addr_i[1:0];
      MEM_SW:  req_strb = NB'(15);
      default: req_strb = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    lane_d    = lane_q;
    addr_d    = addr_q;
    rd_d      = rd_q;
    rd_we_d   = rd_we_q;
    st_data_d = st_data_q;
    st_strb_d = st_strb_q;
    wd_d      = '0;
    wreg_d    = WRITE_DISABLE;
    wdata_d   = '0;
    req       = 1'b0;
    we        = 1'b0;
    stall     = 1'b0;
    misalign  = 1'b0;
    load_done = 1'b0;
    dm_addr_o  = addr_q;
    dm_wdata_o = st_data_q;
    dm_wstrb_o = st_strb_q;
    case (state_q)
      ST_IDLE: begin
        dm_addr_o  = req_addr;
        dm_wdata_o = req_data;
        dm_wstrb_o = req_strb;
        if (valid_i) begin
          if (!(is_load(mem_op_i) || is_store(mem_op_i))) begin
            wd_d    = wd_i;
            wreg_d  = wreg_i;
            wdata_d = wdata_i;
          end else if (is_misaligned(mem_op_i, mem_addr_i[1:0])) begin
            misalign = 1'b1;
          end else begin
            req       = 1'b1;
            we        = is_store(mem_op_i);
            op_d      = mem_op_i;
            lane_d    = mem_addr_i[1:0];
            addr_d    = req_addr;
            rd_d      = wd_i;
            rd_we_d   = wreg_i;
            st_data_d = req_data;
            st_strb_d = req_strb;
            // A store granted in its first cycle finishes without stalling.
            if (!dm_gnt_i) begin
              state_d = ST_REQ;
              stall   = 1'b1;
            end else if (is_load(mem_op_i)) begin
              state_d = ST_WAIT;
              stall   = 1'b1;
            end
          end
        end
      end
      ST_REQ: begin
        req   = 1'b1;
        we    = is_store(op_q);
        stall = 1'b1;
        if (dm_gnt_i) begin
          if (is_store(op_q)) begin
            state_d = ST_IDLE;
            stall   = 1'b0;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (dm_rvalid_i) begin
          state_d   = ST_IDLE;
          stall     = 1'b0;
          load_done = 1'b1;
          wd_d      = rd_q;
          wreg_d    = rd_we_q;
          wdata_d   = load_result;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A load must not forward anything until its data actually arrives.
  always_comb begin
    load_pending = (state_q == ST_IDLE) ? (valid_i && is_load(mem_op_i)) : is_load(op_q);
    mem_wd_o    = wd_i;
    mem_wreg_o  = valid_i && wreg_i;
    mem_wdata_o = wdata_i;
    if (load_done) begin
      mem_wd_o    = rd_q;
      mem_wreg_o  = rd_we_q;
      mem_wdata_o = load_result;
    end else if (load_pending) begin
      mem_wreg_o = WRITE_DISABLE;
    end
  end

  assign dm_req_o   = req && rst;
  assign dm_we_o    = we && rst;
  assign stall_o    = stall && rst;
  assign misalign_o = misalign && rst;
  assign wd_o       = wd_q;
  assign wreg_o     = wreg_q;
  assign wdata_o    = wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      op_q      <= MEM_NONE;
      lane_q    <= '0;
      addr_q    <= '0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      st_data_q <= '0;
      st_strb_q <= '0;
      wd_q      <= '0;
      wreg_q    <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      lane_q    <= lane_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      rd_we_q   <= rd_we_d;
      st_data_q <= st_data_d;
      st_strb_q <= st_strb_d;
      wd_q      <= wd_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios followed by random load/store
// traffic, compared against an arithmetic model of the memory-op rules.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] store_data_i;
  logic        dm_req_o, dm_we_o;
  logic [31:0] dm_addr_o, dm_wdata_o;
  logic [3:0]  dm_wstrb_o;
  logic        dm_gnt_i, dm_rvalid_i;
  logic [31:0] dm_rdata_i;
  logic        stall_o, misalign_o;
  logic [4:0]  wd_o, mem_wd_o;
  logic        wreg_o, mem_wreg_o;
  logic [31:0] wdata_o, mem_wdata_o;

  int total = 0;
  int bad   = 0;

  mem_access_stage #(.XLEN(32), .ADDR_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
    .store_data_i(store_data_i), .dm_req_o(dm_req_o), .dm_we_o(dm_we_o),
    .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o), .dm_wstrb_o(dm_wstrb_o),
    .dm_gnt_i(dm_gnt_i), .dm_rvalid_i(dm_rvalid_i), .dm_rdata_i(dm_rdata_i),
    .stall_o(stall_o), .misalign_o(misalign_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .mem_wd_o(mem_wd_o), .mem_wreg_o(mem_wreg_o),
    .mem_wdata_o(mem_wdata_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic isLoadOp(input logic [3:0] op);
    return op == MEM_LB || op == MEM_LH || op == MEM_LW || op == MEM_LBU || op == MEM_LHU;
  endfunction

  function automatic logic isStoreOp(input logic [3:0] op);
    return op == MEM_SB || op == MEM_SH || op == MEM_SW;
  endfunction

  function automatic logic modelMisaligned(input logic [3:0] op, input logic [31:0] addr);
    if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) return (addr % 2) != 0;
    if (op == MEM_LW || op == MEM_SW) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [3:0] op, input logic [31:0] rdata, input logic [31:0] addr);
    logic [31:0] shifted, b, h;
    shifted = rdata >> (8 * (addr % 4));
    b = shifted & 32'hFF;
    h = shifted & 32'hFFFF;
    case (op)
      MEM_LB:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
      MEM_LBU: return b;
      MEM_LH:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
      MEM_LHU: return h;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] modelStrb(input logic [3:0] op, input logic [31:0] addr);
    case (op)
      MEM_SB:  return 4'(1 << (addr % 4));
      MEM_SH:  return 4'(3 << (addr % 4));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] modelStoreData(input logic [3:0] op, input logic [31:0] sd);
    case (op)
      MEM_SB:  return (sd & 32'hFF) * 32'h01010101;
      MEM_SH:  return (sd & 32'hFFFF) * 32'h00010001;
      default: return sd;
    endcase
  endfunction

  // Drives one instruction through the stage, playing the memory side with
  // the given grant and read-data delays, and checks every cycle of it.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [4:0] wd, input logic wr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int gntDly, input int rvDly, input string tag);
    logic ld, st, mis;
    logic [31:0] expLoad;
    int lastCycle, stallCnt;
    ld = isLoadOp(op);
    st = isStoreOp(op);
    mis = modelMisaligned(op, addr);
    expLoad = modelLoad(op, rdata, addr);
    @(negedge clk);
    valid_i = 1'b1; mem_op_i = op; mem_addr_i = addr; store_data_i = sdata;
    wd_i = wd; wreg_i = wr; wdata_i = wdata;
    dm_gnt_i = 1'b0; dm_rvalid_i = 1'b0; dm_rdata_i = $urandom;
    if (!(ld || st) || mis) begin
      #1;
      checkOutput({tag, ".misalign"}, misalign_o, mis);
      checkOutput({tag, ".req"}, dm_req_o, 0);
      checkOutput({tag, ".stall"}, stall_o, 0);
      if (!mis) checkOutput({tag, ".fwd_wreg"}, mem_wreg_o, wr);
      if (!mis) checkOutput({tag, ".fwd_wdata"}, mem_wdata_o, wdata);
      @(posedge clk); #1;
      checkOutput({tag, ".wreg_o"}, wreg_o, mis ? 1'b0 : wr);
      if (!mis) begin
        checkOutput({tag, ".wd_o"}, wd_o, wd);
        checkOutput({tag, ".wdata_o"}, wdata_o, wdata);
      end
      return;
    end
    lastCycle = st ? gntDly : gntDly + rvDly;
    stallCnt = 0;
    for (int c = 0; c <= lastCycle; c++) begin
      if (c > 0) @(negedge clk);
      dm_gnt_i = (c == gntDly);
      dm_rvalid_i = (ld && c == lastCycle) || (c < gntDly && $urandom_range(0, 1) == 1);
      dm_rdata_i = (ld && c == lastCycle) ? rdata : $urandom;
      #1;
      if (c == 0) checkOutput({tag, ".misalign"}, misalign_o, 0);
      if (c <= gntDly) begin
        checkOutput($sformatf("%s.req%0d", tag, c), dm_req_o, 1);
        checkOutput($sformatf("%s.we%0d", tag, c), dm_we_o, st);
        checkOutput($sformatf("%s.addr%0d", tag, c), dm_addr_o, addr & 32'hFFFFFFFC);
        if (st) begin
          checkOutput($sformatf("%s.strb%0d", tag, c), dm_wstrb_o, modelStrb(op, addr));
          checkOutput($sformatf("%s.wdat%0d", tag, c), dm_wdata_o, modelStoreData(op, sdata));
        end
      end else begin
        checkOutput($sformatf("%s.req%0d", tag, c), dm_req_o, 0);
      end
      checkOutput($sformatf("%s.stall%0d", tag, c), stall_o, c < lastCycle);
      if (stall_o === 1'b1) stallCnt++;
      if (ld) begin
        checkOutput($sformatf("%s.fwd_wreg%0d", tag, c), mem_wreg_o, (c == lastCycle) ? wr : 1'b0);
        if (c == lastCycle) checkOutput({tag, ".fwd_wdata"}, mem_wdata_o, expLoad);
      end
      @(posedge clk); #1;
      if (c < lastCycle) checkOutput($sformatf("%s.bubble%0d", tag, c), wreg_o, 0);
    end
    checkOutput({tag, ".stall_cycles"}, stallCnt, lastCycle);
    if (ld) begin
      checkOutput({tag, ".wreg_o"}, wreg_o, wr);
      checkOutput({tag, ".wd_o"}, wd_o, wd);
      checkOutput({tag, ".wdata_o"}, wdata_o, expLoad);
    end else begin
      checkOutput({tag, ".wreg_o"}, wreg_o, 0);
    end
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] addr;
    rst = 1'b0; valid_i = 1'b0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
    mem_op_i = MEM_NONE; mem_addr_i = '0; store_data_i = '0;
    dm_gnt_i = 1'b0; dm_rvalid_i = 1'b0; dm_rdata_i = '0;

    @(negedge clk); #1;
    checkOutput("reset.req", dm_req_o, 0);
    checkOutput("reset.stall", stall_o, 0);
    checkOutput("reset.misalign", misalign_o, 0);
    checkOutput("reset.wreg_o", wreg_o, 0);
    checkOutput("reset.wd_o", wd_o, 0);
    checkOutput("reset.wdata_o", wdata_o, 0);
    @(negedge clk); rst = 1'b1;

    applyStimulus(MEM_NONE, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 32'h0, 0, 0, "add");

    @(negedge clk); valid_i = 1'b0; wreg_i = 1'b1;
    @(posedge clk); #1;
    checkOutput("bubble.wreg_o", wreg_o, 0);

    applyStimulus(MEM_LB, 32'h1003, 32'h0, 5'd7, 1'b1, 32'h0, 32'h80FFFFFF, 0, 2, "lb");
    applyStimulus(MEM_LHU, 32'h1002, 32'h0, 5'd9, 1'b1, 32'h0, 32'hBEEF0000, 3, 1, "lhu");
    applyStimulus(MEM_SB, 32'h2001, 32'hAB, 5'd0, 1'b0, 32'h0, 32'h0, 0, 0, "sb");
    applyStimulus(MEM_LW, 32'h3002, 32'h0, 5'd4, 1'b1, 32'h0, 32'h0, 0, 0, "lw_mis");

    // Reset while a load waits for its data; a late read beat must be dropped.
    @(negedge clk);
    valid_i = 1'b1; mem_op_i = MEM_LW; mem_addr_i = 32'h4000; wd_i = 5'd3; wreg_i = 1'b1;
    dm_gnt_i = 1'b1; dm_rvalid_i = 1'b0;
    #1; checkOutput("rstmid.req", dm_req_o, 1);
    @(negedge clk);
    valid_i = 1'b0; dm_gnt_i = 1'b0;
    #1; checkOutput("rstmid.wait_stall", stall_o, 1);
    rst = 1'b0;
    #1;
    checkOutput("rstmid.req_low", dm_req_o, 0);
    checkOutput("rstmid.stall_low", stall_o, 0);
    checkOutput("rstmid.wreg_o", wreg_o, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); dm_rvalid_i = 1'b1; dm_rdata_i = 32'hDEADBEEF;
    #1;
    checkOutput("rstmid.late_stall", stall_o, 0);
    checkOutput("rstmid.late_fwd", mem_wreg_o, 0);
    @(posedge clk); #1;
    checkOutput("rstmid.late_wreg", wreg_o, 0);
    @(negedge clk); dm_rvalid_i = 1'b0;

    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 8));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) addr = addr & 32'hFFFFFFFE;
        if (op == MEM_LW || op == MEM_SW) addr = addr & 32'hFFFFFFFC;
      end
      applyStimulus(op, addr, $urandom, 5'($urandom), 1'($urandom), $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(1, 3), $sformatf("rnd%0d", n));
    end

    @(negedge clk); valid_i = 1'b0; dm_gnt_i = 1'b0; dm_rvalid_i = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
